// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding and the PC helper functions.
package if_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam logic [31:0] BOOT_OFFSET = 32'h0000_0080;
  localparam logic [31:0] PC_INC      = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] boot_pc(input logic [31:0] base);
    return word_align(base) + BOOT_OFFSET;
  endfunction

endpackage

// File: rtl/if_fetch_outreg.sv
// Single-entry valid/ready register between fetch and decode.
// A flush drops the held entry; the payload is frozen while it waits.
module if_fetch_outreg
  import if_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        err_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        err_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        err_q;

  // Entry capture, hand-off to decode and flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
      err_q   <= err_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign err_o   = err_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, boot and redirect handling,
// and a single-outstanding req/gnt/rvalid memory handshake.
module if_fetch_ctrl
  import if_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic [31:0] boot_addr_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_target_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        out_valid_o,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_err_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic        booted_q, booted_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] redir_pend_q, redir_pend_d;
  logic        busy_q;

  logic        out_valid_s;
  logic        req_s;
  logic        fire_s;
  logic        load_s;
  logic [31:0] load_instr_s;
  logic        load_err_s;
  logic [31:0] target_s;
  state_e      resume_s;

  // A request only goes out when the output register is guaranteed free.
  assign req_s    = (state_q == REQ) && (!out_valid_s || out_ready_i);
  assign fire_s   = req_s && instr_gnt_i;
  assign target_s = word_align(pc_target_i);
  assign resume_s = fetch_enable_i ? REQ : IDLE;

  // Next-state, PC and redirect bookkeeping.
  always_comb begin
    state_d      = state_q;
    booted_d     = booted_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    redir_pend_d = redir_pend_q;
    load_s       = 1'b0;
    load_instr_s = 32'h0000_0000;
    load_err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_set_i) begin
          pc_d     = target_s;
          booted_d = 1'b1;
          state_d  = resume_s;
        end else if (!booted_q) begin
          pc_d = boot_pc(boot_addr_i);
          if (fetch_enable_i) begin
            booted_d = 1'b1;
            state_d  = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = resume_s;
        end
      end
      REQ: begin
        if (fire_s) begin
          state_d = WAIT;
          if (pc_set_i) begin
            discard_d    = 1'b1;
            redir_pend_d = target_s;
          end else begin
            discard_d = discard_q;
          end
        end else if (pc_set_i) begin
          pc_d    = target_s;
          state_d = resume_s;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (instr_rvalid_i) begin
          // A redirect in the response cycle wins over the data.
          if (pc_set_i) begin
            pc_d      = target_s;
            discard_d = 1'b0;
            state_d   = resume_s;
          end else if (discard_q) begin
            pc_d      = redir_pend_q;
            discard_d = 1'b0;
            state_d   = resume_s;
          end else begin
            load_s       = 1'b1;
            load_instr_s = instr_err_i ? 32'h0000_0000 : instr_rdata_i;
            load_err_s   = instr_err_i;
            if (instr_err_i) begin
              state_d = HALT;
            end else begin
              pc_d    = pc_q + PC_INC;
              state_d = resume_s;
            end
          end
        end else if (pc_set_i) begin
          discard_d    = 1'b1;
          redir_pend_d = target_s;
        end else begin
          state_d = WAIT;
        end
      end
      HALT: begin
        if (pc_set_i) begin
          pc_d    = target_s;
          state_d = resume_s;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      booted_q     <= 1'b0;
      pc_q         <= boot_pc(boot_addr_i);
      discard_q    <= 1'b0;
      redir_pend_q <= 32'h0000_0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      booted_q     <= booted_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      redir_pend_q <= redir_pend_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  if_fetch_outreg u_outreg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (pc_set_i),
    .load_i  (load_s),
    .instr_i (load_instr_s),
    .pc_i    (pc_q),
    .err_i   (load_err_s),
    .ready_i (out_ready_i),
    .valid_o (out_valid_s),
    .instr_o (out_instr_o),
    .pc_o    (out_pc_o),
    .err_o   (out_err_o)
  );

  assign instr_req_o  = req_s;
  assign instr_addr_o = (state_q == REQ) ? pc_q : 32'h0000_0000;
  assign out_valid_o  = out_valid_s;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: boot, backpressure, redirects,
// bus error, PC wrap with grant stall, fetch disable and mid-WAIT reset.
module tb_if_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_enable_i;
  logic [31:0] boot_addr_i;
  logic        pc_set_i;
  logic [31:0] pc_target_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        out_valid_o;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_err_o;
  logic        out_ready_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  if_fetch_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_enable_i (fetch_enable_i),
    .boot_addr_i    (boot_addr_i),
    .pc_set_i       (pc_set_i),
    .pc_target_i    (pc_target_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .out_valid_o    (out_valid_o),
    .out_instr_o    (out_instr_o),
    .out_pc_o       (out_pc_o),
    .out_err_o      (out_err_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Grant the pending request, then answer it one cycle later.
  task automatic do_fetch(input logic [31:0] data, input logic err);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data;
    instr_err_i    = err;
    tick();
    instr_rvalid_i = 1'b0;
    instr_err_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", instr_req_o); end
    checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", instr_addr_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (out_pc_o !== 32'h0 || out_instr_o !== 32'h0 || out_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_out got pc %h instr %h err %b exp all 0", out_pc_o, out_instr_o, out_err_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_boot();
    logic [31:0] data;
    fetch_enable_i = 1'b1;
    #1;
    checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL boot_req_early got %b exp 0", instr_req_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      data = 32'hA000_0000 + 32'(i);
      checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL boot_req[%0d] got %b exp 1", i, instr_req_o); end
      checks++; if (instr_addr_o !== 32'h1080 + 32'(4 * i)) begin
        errors++; $display("FAIL boot_addr[%0d] got %h exp %h", i, instr_addr_o, 32'h1080 + 32'(4 * i));
      end
      do_fetch(data, 1'b0);
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL boot_valid[%0d] got %b exp 1", i, out_valid_o); end
      checks++; if (out_pc_o !== 32'h1080 + 32'(4 * i)) begin
        errors++; $display("FAIL boot_pc[%0d] got %h exp %h", i, out_pc_o, 32'h1080 + 32'(4 * i));
      end
      checks++; if (out_instr_o !== data) begin errors++; $display("FAIL boot_instr[%0d] got %h exp %h", i, out_instr_o, data); end
    end
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL bp_req[%0d] got %b exp 0", i, instr_req_o); end
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid_o); end
      checks++; if (out_instr_o !== 32'hA000_0002) begin
        errors++; $display("FAIL bp_instr[%0d] got %h exp a0000002", i, out_instr_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL bp_release_req got %b exp 1", instr_req_o); end
    checks++; if (instr_addr_o !== 32'h108C) begin errors++; $display("FAIL bp_release_addr got %h exp 108c", instr_addr_o); end
    do_fetch(32'hB000_0000, 1'b0);
    checks++; if (out_pc_o !== 32'h108C) begin errors++; $display("FAIL bp_pc got %h exp 108c", out_pc_o); end
  endtask

  task automatic test_redirect_wait();
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    pc_set_i    = 1'b1;
    pc_target_i = 32'h2000;
    tick();
    pc_set_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", out_valid_o); end
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hDEAD_BEEF;
    tick();
    instr_rvalid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL redir_dropped got %b exp 0", out_valid_o); end
    checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL redir_req got %b exp 1", instr_req_o); end
    checks++; if (instr_addr_o !== 32'h2000) begin errors++; $display("FAIL redir_addr got %h exp 2000", instr_addr_o); end
  endtask

  task automatic test_redirect_same_cycle();
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hCAFE_0000;
    pc_set_i       = 1'b1;
    pc_target_i    = 32'h2400;
    tick();
    instr_rvalid_i = 1'b0;
    pc_set_i       = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL same_valid got %b exp 0", out_valid_o); end
    checks++; if (instr_addr_o !== 32'h2400) begin errors++; $display("FAIL same_addr got %h exp 2400", instr_addr_o); end
    checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL same_req got %b exp 1", instr_req_o); end
  endtask

  task automatic test_bus_error();
    do_fetch(32'h1234_5678, 1'b1);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL err_valid got %b exp 1", out_valid_o); end
    checks++; if (out_err_o !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", out_err_o); end
    checks++; if (out_instr_o !== 32'h0) begin errors++; $display("FAIL err_instr got %h exp 0", out_instr_o); end
    checks++; if (out_pc_o !== 32'h2400) begin errors++; $display("FAIL err_pc got %h exp 2400", out_pc_o); end
    checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL err_halt got req %b busy %b exp req 0 busy 1", instr_req_o, busy_o);
    end
    tick();
    checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL halt_req got %b exp 0", instr_req_o); end
    pc_set_i    = 1'b1;
    pc_target_i = 32'h3000;
    tick();
    pc_set_i = 1'b0;
    checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL halt_exit_req got %b exp 1", instr_req_o); end
    checks++; if (instr_addr_o !== 32'h3000) begin errors++; $display("FAIL halt_exit_addr got %h exp 3000", instr_addr_o); end
  endtask

  task automatic test_wrap_stall();
    pc_set_i    = 1'b1;
    pc_target_i = 32'hFFFF_FFFC;
    tick();
    pc_set_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'hFFFF_FFFC) begin
        errors++; $display("FAIL stall[%0d] got req %b addr %h exp 1 fffffffc", i, instr_req_o, instr_addr_o);
      end
      tick();
    end
    do_fetch(32'h0BAD_F00D, 1'b0);
    checks++; if (out_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", out_pc_o); end
    checks++; if (out_instr_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL wrap_instr got %h exp 0badf00d", out_instr_o); end
    checks++; if (instr_addr_o !== 32'h0 || instr_req_o !== 1'b1) begin
      errors++; $display("FAIL wrap_addr got req %b addr %h exp 1 0", instr_req_o, instr_addr_o);
    end
  endtask

  task automatic test_fetch_disable();
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    fetch_enable_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h5555_AAAA;
    tick();
    instr_rvalid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h0) begin
      errors++; $display("FAIL dis_out got valid %b pc %h exp 1 0", out_valid_o, out_pc_o);
    end
    checks++; if (busy_o !== 1'b0 || instr_req_o !== 1'b0) begin
      errors++; $display("FAIL dis_idle got busy %b req %b exp 0 0", busy_o, instr_req_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    fetch_enable_i = 1'b1;
    tick();
    checks++; if (instr_addr_o !== 32'h4) begin errors++; $display("FAIL rst_pre_addr got %h exp 4", instr_addr_o); end
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    fetch_enable_i = 1'b0;
    rst_i          = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid got busy %b valid %b exp 0 0", busy_o, out_valid_o);
    end
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h7777_7777;
    tick();
    instr_rvalid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL late_rvalid got %b exp 0", out_valid_o); end
    boot_addr_i    = 32'h0000_5002;
    fetch_enable_i = 1'b1;
    tick();
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h5080) begin
      errors++; $display("FAIL reboot got req %b addr %h exp 1 5080", instr_req_o, instr_addr_o);
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    fetch_enable_i = 1'b0;
    boot_addr_i    = 32'h0000_1000;
    pc_set_i       = 1'b0;
    pc_target_i    = 32'h0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    instr_err_i    = 1'b0;
    out_ready_i    = 1'b1;
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_bus_error();
    test_wrap_stall();
    test_fetch_disable();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
